dsm_stereo_decoder: RTL and testbench
=====================================

Name: dsm_stereo_decoder

Overview:
- Stereo 1-bit delta-sigma decoder (the input counterpart of the audio DSM output path).
- Takes two external 1-bit DSM bitstreams, e.g. from comparator/RC front ends, clocked at 44.1 kHz * 2^AUDIO_BITS (clk_audio from the audio PLL).
- Each channel is decimated by integrate-and-dump over 2^AUDIO_BITS clocks into an unsigned AUDIO_BITS-bit PCM word.
- Left/right words are packed into the same {left,right} sample layout the audio output path uses, with a valid/read-request handshake and sticky overrun flag.

Parameters:
AUDIO_BITS, 12, PCM width per channel; decimation window = 2^AUDIO_BITS clocks.

Ports:
clk  input  1  audio clock (44.1 kHz * 2^AUDIO_BITS); all logic on rising edge
aclr_  input  1  asynchronous clear, active low
left_in  input  1  left DSM bitstream, asynchronous to clk
right_in  input  1  right DSM bitstream, asynchronous to clk
rreq  input  1  read request; consumer takes sample in the same cycle it asserts rreq with valid=1
ovr_clr  input  1  synchronous clear of overrun flag
sample  output  2*AUDIO_BITS  {left[2N-1:N], right[N-1:0]}, unsigned offset binary
valid  output  1  sample holds an unread word
overrun  output  1  sticky: an unread word was overwritten

Behaviour:
- Reset (aclr_ low, asynchronous): sync flops=0, window counter=0, accumulators=0, sample=0, valid=0, overrun=0. Reset mid-window discards the partial window; counting restarts at 0 on the first edge after release.
- Input sync: 2-flop synchronizer per channel; the synchronized bit is the accumulator input (2-cycle input latency).
- Window counter: N-bit, increments every clock, wraps 2^N-1 -> 0. Dump cycle = counter all-ones.
- Accumulator per channel, N+1 bits:
  - Non-dump cycle: acc <= acc + bit.
  - Dump cycle: result = acc + bit, giving exactly 2^N bits per window; acc <= 0.
- Saturation: result 2^N clamps to 2^N-1. Range 0..2^N-1; midscale (50% density) = 2^(N-1).
- Output register (dump cycle): sample <= {left_result, right_result}; valid <= 1.
- Handshake:
  - rreq && valid, no dump: valid <= 0 next edge; sample holds.
  - rreq && !valid: ignored.
  - Dump and rreq in the same cycle: consumer receives the old word; new word is loaded; valid stays 1; no overrun.
  - Dump with valid=1 and no rreq: sample overwritten with the new word; overrun <= 1.
- Overrun:
  - Clears only on reset, or on ovr_clr with no simultaneous setting event.
  - Set wins over ovr_clr in the same cycle.
- Throughput: one sample per 2^N clocks (44.1 kHz). Sample latency: the window is closed on the dump edge, and valid rises on that edge.

Decomposition:
- Shared audio package: default AUDIO_BITS constant; helper constants for window length (2^N) and midscale (2^(N-1)), shared with the output path.
- Sub-module dsm_decimator_channel: synchronizer, accumulator, saturation, result output. Takes a dump strobe from the parent; instantiated twice.
- Parent owns: window counter, output register, valid/overrun logic.

Test Plan (AUDIO_BITS=12 unless noted):
1. Both inputs held 0 from reset; first dump on the 4096th edge after release -> valid=1, sample=24'h000000, overrun=0.
2. Both inputs held 1; check the second window onward -> sample=24'hFFFFFF (4096 saturated to 4095). The first window reads 4094 because of synchronizer fill.
3. left toggling 1,0,1,0..., right high one clock in four; read each window with rreq -> steady-state sample = {12'h800, 12'h400}; valid drops the edge after rreq.
4. No rreq for two consecutive dumps -> overrun=1, sample holds the newest window; pulse ovr_clr -> overrun=0. Check ovr_clr coinciding with an overwriting dump leaves overrun=1.
5. rreq asserted exactly in the dump cycle with valid=1 -> valid stays 1, overrun stays 0, sample updates to the new window.
6. aclr_ low for 3 clocks mid-window (counter ~2000) with valid=1 -> sample=0, valid=0, overrun=0 immediately. After release, next valid exactly 4096 edges later.

Source files
------------

// File: rtl/dsm_stereo_decoder_pkg.sv
// Shared audio constants for the DSM input and output paths.
// Window length is 2^AUDIO_BITS clocks; midscale is the 50%-density code.
package dsm_stereo_decoder_pkg;

   localparam int DEF_AUDIO_BITS = 12;
   localparam int WINDOW_LEN     = 1 << DEF_AUDIO_BITS;
   localparam int MIDSCALE       = 1 << (DEF_AUDIO_BITS - 1);

   function automatic int window_len(input int n);
      return 1 << n;
   endfunction

   function automatic int midscale(input int n);
      return 1 << (n - 1);
   endfunction

endpackage

// File: rtl/dsm_decimator_channel.sv
// One DSM channel: 2-flop synchronizer, integrate-and-dump accumulator and
// saturation of the full-scale count 2^N down to 2^N-1.
module dsm_decimator_channel
   import dsm_stereo_decoder_pkg::*;
#(
   parameter int N = DEF_AUDIO_BITS
) (
   input  logic         clk,
   input  logic         aclr_,
   input  logic         bit_i,
   input  logic         dump_i,
   output logic [N-1:0] result_o
);

   logic         sync1_q;
   logic         sync2_q;
   logic [N:0]   acc_q;
   logic [N:0]   acc_d;
   logic [N:0]   sum_s;

   assign sum_s = acc_q + {{N{1'b0}}, sync2_q};

   // Next accumulator value and clamped window result.
   always_comb begin
      acc_d    = sum_s;
      result_o = sum_s[N-1:0];
      if (sum_s[N]) begin
         result_o = {N{1'b1}};
      end else begin
         result_o = sum_s[N-1:0];
      end
      if (dump_i) begin
         acc_d = {(N+1){1'b0}};
      end else begin
         acc_d = sum_s;
      end
   end

   // Synchronizer and accumulator state.
   always_ff @(posedge clk or negedge aclr_) begin
      if (!aclr_) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         acc_q   <= {(N+1){1'b0}};
      end else begin
         sync1_q <= bit_i;
         sync2_q <= sync1_q;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: rtl/dsm_stereo_decoder.sv
// Stereo 1-bit DSM decoder: shared window counter, two decimator channels,
// {left,right} sample register with valid/rreq handshake and sticky overrun.
module dsm_stereo_decoder
   import dsm_stereo_decoder_pkg::*;
#(
   parameter int AUDIO_BITS = DEF_AUDIO_BITS
) (
   input  logic                    clk,
   input  logic                    aclr_,
   input  logic                    left_in,
   input  logic                    right_in,
   input  logic                    rreq,
   input  logic                    ovr_clr,
   output logic [2*AUDIO_BITS-1:0] sample,
   output logic                    valid,
   output logic                    overrun
);

   logic [AUDIO_BITS-1:0]   cnt_q;
   logic [AUDIO_BITS-1:0]   cnt_d;
   logic [2*AUDIO_BITS-1:0] sample_q;
   logic [2*AUDIO_BITS-1:0] sample_d;
   logic                    valid_q;
   logic                    valid_d;
   logic                    overrun_q;
   logic                    overrun_d;
   logic                    dump_s;
   logic                    ovr_set_s;
   logic [AUDIO_BITS-1:0]   left_s;
   logic [AUDIO_BITS-1:0]   right_s;

   assign dump_s = &cnt_q;

   dsm_decimator_channel #(.N(AUDIO_BITS)) u_left (
      .clk      (clk),
      .aclr_    (aclr_),
      .bit_i    (left_in),
      .dump_i   (dump_s),
      .result_o (left_s)
   );

   dsm_decimator_channel #(.N(AUDIO_BITS)) u_right (
      .clk      (clk),
      .aclr_    (aclr_),
      .bit_i    (right_in),
      .dump_i   (dump_s),
      .result_o (right_s)
   );

   // A dump while a word is still unread and not being taken is an overwrite.
   assign ovr_set_s = dump_s & valid_q & ~rreq;

   // Next-state for counter, sample register and handshake flags.
   always_comb begin
      cnt_d     = cnt_q + {{(AUDIO_BITS-1){1'b0}}, 1'b1};
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (dump_s) begin
         sample_d = {left_s, right_s};
         valid_d  = 1'b1;
      end else if (rreq && valid_q) begin
         sample_d = sample_q;
         valid_d  = 1'b0;
      end else begin
         sample_d = sample_q;
         valid_d  = valid_q;
      end
      if (ovr_set_s) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Parent state registers.
   always_ff @(posedge clk or negedge aclr_) begin
      if (!aclr_) begin
         cnt_q     <= {AUDIO_BITS{1'b0}};
         sample_q  <= {(2*AUDIO_BITS){1'b0}};
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign sample  = sample_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_dsm_stereo_decoder.sv
// Directed bench: stimulus queues expected read words, a negedge monitor
// pops and compares them whenever a read handshake is presented.
module tb_dsm_stereo_decoder;
   import dsm_stereo_decoder_pkg::*;

   localparam int N = DEF_AUDIO_BITS;
   localparam int W = WINDOW_LEN;

   logic           clk      = 1'b0;
   logic           aclr_    = 1'b0;
   logic           left_in  = 1'b0;
   logic           right_in = 1'b0;
   logic           rreq     = 1'b0;
   logic           ovr_clr  = 1'b0;
   logic [2*N-1:0] sample;
   logic           valid;
   logic           overrun;

   int             n_checks = 0;
   int             n_pass   = 0;
   int             ecount   = 0;
   int             mode     = 0;
   logic [2*N-1:0] exp_q[$];
   logic [2*N-1:0] mon_exp;

   dsm_stereo_decoder #(.AUDIO_BITS(N)) dut (
      .clk      (clk),
      .aclr_    (aclr_),
      .left_in  (left_in),
      .right_in (right_in),
      .rreq     (rreq),
      .ovr_clr  (ovr_clr),
      .sample   (sample),
      .valid    (valid),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, ecount);
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      ecount++;
      case (mode)
         0: begin left_in = 1'b0; right_in = 1'b0; end
         1: begin left_in = 1'b1; right_in = 1'b1; end
         default: begin
            left_in  = ((ecount % 2) == 1);
            right_in = ((ecount % 4) == 0);
         end
      endcase
   endtask

   task automatic run_to(input int t);
      while (ecount < t) step();
   endtask

   task automatic do_read(input logic [2*N-1:0] e);
      exp_q.push_back(e);
      rreq = 1'b1;
      step();
      rreq = 1'b0;
   endtask

   task automatic reset_and_release(input int m);
      mode  = m;
      aclr_ = 1'b0;
      step();
      step();
      aclr_  = 1'b1;
      ecount = 0;
   endtask

   // Monitor: every read handshake must deliver the next queued word.
   initial begin
      forever begin
         @(negedge clk);
         if (aclr_ && rreq && valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL read_unexpected: got sample %0h, no expected word queued", sample);
            end else begin
               mon_exp = exp_q.pop_front();
               check("read_sample", {8'h00, sample}, {8'h00, mon_exp});
            end
         end
      end
   end

   initial begin
      // 1: reset state and first window of zeros
      step(); step(); step();
      check("reset_sample", {8'h00, sample}, 32'h0);
      check("reset_valid", {31'h0, valid}, 32'h0);
      check("reset_overrun", {31'h0, overrun}, 32'h0);
      aclr_  = 1'b1;
      ecount = 0;
      run_to(W - 1);
      check("no_early_valid", {31'h0, valid}, 32'h0);
      step();
      check("first_valid", {31'h0, valid}, 32'h1);
      check("first_overrun", {31'h0, overrun}, 32'h0);
      do_read(24'h000000);
      check("valid_drop_after_read", {31'h0, valid}, 32'h0);

      // 2 and 5: all ones, rreq landing on the dump cycle
      reset_and_release(1);
      run_to(W);
      check("ones_w1_valid", {31'h0, valid}, 32'h1);
      run_to(2 * W - 1);
      exp_q.push_back(24'hFFEFFE);
      rreq = 1'b1;
      step();
      rreq = 1'b0;
      check("dump_rreq_valid", {31'h0, valid}, 32'h1);
      check("dump_rreq_overrun", {31'h0, overrun}, 32'h0);
      do_read(24'hFFFFFF);

      // 3 and 4: patterned inputs, overrun set/clear, set beats clear
      reset_and_release(2);
      run_to(W);
      check("pat_w1_overrun", {31'h0, overrun}, 32'h0);
      run_to(2 * W);
      check("overrun_set", {31'h0, overrun}, 32'h1);
      do_read(24'h800400);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      check("overrun_cleared", {31'h0, overrun}, 32'h0);
      run_to(3 * W);
      do_read(24'h800400);
      check("pat_valid_drop", {31'h0, valid}, 32'h0);
      run_to(5 * W - 1);
      check("pre_overwrite_overrun", {31'h0, overrun}, 32'h0);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      check("set_wins_over_clr", {31'h0, overrun}, 32'h1);
      do_read(24'h800400);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      check("overrun_cleared2", {31'h0, overrun}, 32'h0);

      // 6: asynchronous clear mid-window
      run_to(6 * W + 2000);
      check("mid_valid", {31'h0, valid}, 32'h1);
      check("mid_sample", {8'h00, sample}, 32'h00800400);
      aclr_ = 1'b0;
      #1;
      check("aclr_sample", {8'h00, sample}, 32'h0);
      check("aclr_valid", {31'h0, valid}, 32'h0);
      check("aclr_overrun", {31'h0, overrun}, 32'h0);
      step(); step(); step();
      aclr_  = 1'b1;
      ecount = 0;
      run_to(W - 1);
      check("post_aclr_no_early", {31'h0, valid}, 32'h0);
      step();
      check("post_aclr_valid", {31'h0, valid}, 32'h1);

      repeat (3) step();
      check("queue_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
